// File: rtl/result_writer_if.sv
`default_nettype none
// ============================================================================
// result_writer_if : pixel-in handshake and memory write-port bundle for result_writer
// Rev 1.0
// ============================================================================
interface result_writer_if #(
   parameter int WORD       = 32,
   parameter int INPUT_SIZE = 8
) ();
   logic [INPUT_SIZE-1:0] in_data;
   logic                  in_valid;
   logic                  in_ready;
   logic                  w_stall;
   logic                  w_en;
   logic [WORD-1:0]       w_addr;
   logic [INPUT_SIZE-1:0] w_data;

   modport master (
      output in_data, in_valid, w_stall,
      input  in_ready, w_en, w_addr, w_data
   );

   modport slave (
      input  in_data, in_valid, w_stall,
      output in_ready, w_en, w_addr, w_data
   );
endinterface
`default_nettype wire

// File: rtl/result_writer.sv
`default_nettype none
// ============================================================================
// result_writer : buffers filtered pixels in a FIFO and writes them to the output
//                 image at base h*w. RESULT_WRITER_COMPACT_EN selects base+k layout.
// Rev 1.0
// ============================================================================
module result_writer #(
   parameter int WORD       = 32,
   parameter int INPUT_SIZE = 8,
   parameter int MAX_N      = 25,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic [WORD-1:0]          h,
   input  logic [WORD-1:0]          w,
   input  logic [$clog2(MAX_N)-1:0] n,
   result_writer_if.slave           bus,
   output logic                     busy,
   output logic                     done,
   output logic                     err
);
   localparam int NW = $clog2(MAX_N);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
   localparam logic [WORD-1:0] WORD_ONE = {{(WORD-1){1'b0}}, 1'b1};
   localparam logic [PW-1:0]   PTR_ONE  = {{(PW-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t                r_state;
   logic [INPUT_SIZE-1:0] r_mem [FIFO_DEPTH];
   logic [PW-1:0]         r_wr_ptr;
   logic [PW-1:0]         r_rd_ptr;
   logic [CW-1:0]         r_count;
   logic [WORD-1:0]       r_total;
   logic [WORD-1:0]       r_accepted;
   logic [WORD-1:0]       r_written;
   logic                  r_in_ready;
   logic                  r_w_en;
   logic [WORD-1:0]       r_w_addr;
   logic [INPUT_SIZE-1:0] r_w_data;
   logic                  r_busy;
   logic                  r_done;
   logic                  r_err;

   logic [WORD-1:0]       w_n_ext;
   logic [WORD-1:0]       w_r;
   logic [WORD-1:0]       w_rows;
   logic [WORD-1:0]       w_cols;
   logic [WORD-1:0]       w_total;
   logic [WORD-1:0]       w_base;
   logic                  w_bad;
   logic                  w_push;
   logic                  w_pop;
   logic [CW-1:0]         w_count_nxt;
   logic [WORD-1:0]       w_accepted_nxt;
   logic [WORD-1:0]       w_next_addr;

   assign w_n_ext = {{(WORD-NW){1'b0}}, n};
   assign w_r     = w_n_ext >> 1;
   assign w_rows  = h - (w_r << 1);
   assign w_cols  = w - (w_r << 1);
   assign w_total = w_rows * w_cols;
   assign w_base  = h * w;
   // n==0 is caught by the even test
   assign w_bad   = (n[0] == 1'b0) || (w_n_ext > WORD'(MAX_N)) ||
                    (w_n_ext > h) || (w_n_ext > w);

   assign w_push         = bus.in_valid && r_in_ready;
   assign w_pop          = (r_state == S_RUN) && (r_count != '0) && !bus.w_stall;
   assign w_count_nxt    = r_count + {{PW{1'b0}}, w_push} - {{PW{1'b0}}, w_pop};
   assign w_accepted_nxt = r_accepted + {{(WORD-1){1'b0}}, w_push};

`ifdef RESULT_WRITER_COMPACT_EN
   logic [WORD-1:0] r_base;
   assign w_next_addr = r_base + r_written;
`else
   logic [WORD-1:0] r_width;
   logic [WORD-1:0] r_cols;
   logic [WORD-1:0] r_col;
   logic [WORD-1:0] r_row_addr;
   logic [WORD-1:0] w_row0_addr;
   // r_row_addr holds base+(row+r)*w+r, so the column is just added on
   assign w_row0_addr = w_base + w_r * w + w_r;
   assign w_next_addr = r_row_addr + r_col;
`endif

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= bus.in_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_total    <= '0;
         r_accepted <= '0;
         r_written  <= '0;
         r_in_ready <= 1'b0;
         r_w_en     <= 1'b0;
         r_w_addr   <= '0;
         r_w_data   <= '0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_err      <= 1'b0;
`ifdef RESULT_WRITER_COMPACT_EN
         r_base     <= '0;
`else
         r_width    <= '0;
         r_cols     <= '0;
         r_col      <= '0;
         r_row_addr <= '0;
`endif
      end else begin
         r_w_en     <= 1'b0;
         r_done     <= 1'b0;
         r_count    <= w_count_nxt;
         r_accepted <= w_accepted_nxt;
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + PTR_ONE;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PTR_ONE;
         end

         case (r_state)
            S_IDLE: begin
               r_in_ready <= 1'b0;
               if (start) begin
                  if (w_bad) begin
                     r_err   <= 1'b1;
                     r_done  <= 1'b1;
                     r_state <= S_DONE;
                  end else begin
                     r_err      <= 1'b0;
                     r_busy     <= 1'b1;
                     r_in_ready <= 1'b1;
                     r_total    <= w_total;
                     r_accepted <= '0;
                     r_written  <= '0;
                     r_state    <= S_RUN;
`ifdef RESULT_WRITER_COMPACT_EN
                     r_base     <= w_base;
`else
                     r_width    <= w;
                     r_cols     <= w_cols;
                     r_col      <= '0;
                     r_row_addr <= w_row0_addr;
`endif
                  end
               end
            end

            S_RUN: begin
               r_in_ready <= (w_count_nxt < CW'(FIFO_DEPTH)) && (w_accepted_nxt < r_total);
               if (w_pop) begin
                  r_w_en    <= 1'b1;
                  r_w_data  <= r_mem[r_rd_ptr];
                  r_w_addr  <= w_next_addr;
                  r_written <= r_written + WORD_ONE;
`ifndef RESULT_WRITER_COMPACT_EN
                  if (r_col == r_cols - WORD_ONE) begin
                     r_col      <= '0;
                     r_row_addr <= r_row_addr + r_width;
                  end else begin
                     r_col <= r_col + WORD_ONE;
                  end
`endif
               end
               // Checked one cycle after the final pop so done trails the last w_en
               if (r_written == r_total) begin
                  r_in_ready <= 1'b0;
                  r_busy     <= 1'b0;
                  r_done     <= 1'b1;
                  r_state    <= S_DONE;
               end
            end

            S_DONE: begin
               r_in_ready <= 1'b0;
               r_state    <= S_IDLE;
            end

            default: begin
               r_in_ready <= 1'b0;
               r_busy     <= 1'b0;
               r_state    <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.in_ready = r_in_ready;
   assign bus.w_en     = r_w_en;
   assign bus.w_addr   = r_w_addr;
   assign bus.w_data   = r_w_data;
   assign busy         = r_busy;
   assign done         = r_done;
   assign err          = r_err;

endmodule
`default_nettype wire
